uart_rx_byte: RTL and testbench

//   8N1 UART receiver: receive side of the UART example, directly downstream of the TX block's tx_pin.

---
 rtl/uart_rx_byte.sv | 200 ++++++++++++++++++++
 tb/tb_uart_rx_byte.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver with a valid/ready output holding register, framing and overrun detection.
// Optional even-parity checking is enabled by defining UART_RX_PARITY_EN.
module uart_rx_byte #(
  parameter int SIZE_COUNTER  = 7,
  parameter int LIMIT_COUNTER = 103
) (
  input  logic       clk_hw,
  input  logic       rst_n,
  input  logic       rx_pin,
  input  logic       data_ready,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       busy,
  output logic       frame_err,
  output logic       overrun,
  output logic       parity_err
);

  // Output handshake: data_out is offered while data_valid=1 and is taken on any
  // cycle where data_valid and data_ready are both 1; data_out never changes while
  // data_valid=1 unless the same cycle is a transfer and a new byte completes.

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_PARITY    = 3'd3,
    S_STOP      = 3'd4,
    S_WAIT_HIGH = 3'd5
  } state_t;

  localparam logic [SIZE_COUNTER-1:0] CNT_FULL = SIZE_COUNTER'(LIMIT_COUNTER);
  localparam logic [SIZE_COUNTER-1:0] CNT_HALF = SIZE_COUNTER'(LIMIT_COUNTER >> 1);

  state_t                  state_q, state_d;
  logic [SIZE_COUNTER-1:0] cnt_q, cnt_d;
  logic [2:0]              idx_q, idx_d;
  logic [7:0]              shift_q, shift_d;
  logic [7:0]              data_out_q, data_out_d;
  logic                    data_valid_q, data_valid_d;
  logic                    frame_err_q, frame_err_d;
  logic                    overrun_q, overrun_d;
  logic                    parity_err_q, parity_err_d;
  logic                    par_bad_q, par_bad_d;
  logic                    rx_meta_q, rx_meta_d;
  logic                    rx_s_q, rx_s_d;
  logic                    deliver;
  logic                    at_half;
  logic                    at_full;

  assign at_half = (cnt_q == CNT_HALF);
  assign at_full = (cnt_q == CNT_FULL);

  always_comb begin
    rx_meta_d    = rx_pin;
    rx_s_d       = rx_meta_q;
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    shift_d      = shift_q;
    par_bad_d    = par_bad_q;
    frame_err_d  = 1'b0;
    parity_err_d = 1'b0;
    deliver      = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rx_s_q) begin
          state_d = S_START;
        end
      end

      S_START: begin
        if (at_half) begin
          cnt_d = '0;
          idx_d = 3'd0;
          // A high line at mid-start is a glitch, not a frame
          state_d = rx_s_q ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_DATA: begin
        if (at_full) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_s_q;
          idx_d          = idx_q + 3'd1;
          par_bad_d      = 1'b0;
          if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (at_full) begin
          cnt_d        = '0;
          parity_err_d = (^shift_q) ^ rx_s_q;
          par_bad_d    = (^shift_q) ^ rx_s_q;
          state_d      = S_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif

      S_STOP: begin
        if (at_full) begin
          cnt_d = '0;
          if (rx_s_q) begin
            // Leave half a bit early so a back-to-back start edge is not missed
            state_d = S_IDLE;
            deliver = !par_bad_q;
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_WAIT_HIGH: begin
        cnt_d = '0;
        if (rx_s_q) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Holding register: a completed byte lands if the slot is empty or being drained
  always_comb begin
    data_out_d   = data_out_q;
    data_valid_d = data_valid_q;
    overrun_d    = 1'b0;
    if (deliver) begin
      if (!data_valid_q || data_ready) begin
        data_out_d   = shift_q;
        data_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (data_valid_q && data_ready) begin
      data_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_hw) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      idx_q        <= 3'd0;
      shift_q      <= 8'h00;
      data_out_q   <= 8'h00;
      data_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
      parity_err_q <= 1'b0;
      par_bad_q    <= 1'b0;
      rx_meta_q    <= 1'b1;
      rx_s_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shift_q      <= shift_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
      parity_err_q <= parity_err_d;
      par_bad_q    <= par_bad_d;
      rx_meta_q    <= rx_meta_d;
      rx_s_q       <= rx_s_d;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign busy       = (state_q != S_IDLE);
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
  assign parity_err = parity_err_q;

endmodule

// File: tb/tb_uart_rx_byte.sv
// Directed bench for uart_rx_byte at 16 clocks per bit; frame table plus hand-written corner sequences.
module tb_uart_rx_byte;

  localparam int BIT_CYC = 16;

  logic       clk_hw = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_pin = 1'b0;
  logic       data_ready = 1'b1;
  logic [7:0] data_out;
  logic       data_valid;
  logic       busy;
  logic       frame_err;
  logic       overrun;
  logic       parity_err;

  uart_rx_byte #(
    .SIZE_COUNTER (4),
    .LIMIT_COUNTER(15)
  ) dut (
    .clk_hw    (clk_hw),
    .rst_n     (rst_n),
    .rx_pin    (rx_pin),
    .data_ready(data_ready),
    .data_out  (data_out),
    .data_valid(data_valid),
    .busy      (busy),
    .frame_err (frame_err),
    .overrun   (overrun),
    .parity_err(parity_err)
  );

  // clock / reset
  initial begin
    forever #5 clk_hw = ~clk_hw;
  end

  // Event counters sampled on the falling edge, away from the active edge
  int valid_cyc = 0;
  int fe_cnt    = 0;
  int ov_cnt    = 0;
  int pe_cnt    = 0;
  always @(negedge clk_hw) begin
    if (data_valid === 1'b1) valid_cyc <= valid_cyc + 1;
    if (frame_err === 1'b1) fe_cnt <= fe_cnt + 1;
    if (overrun === 1'b1) ov_cnt <= ov_cnt + 1;
    if (parity_err === 1'b1) pe_cnt <= pe_cnt + 1;
  end

  int b_valid, b_fe, b_ov, b_pe;
  int n_checks = 0;
  int n_errors = 0;

  task automatic snap();
    b_valid = valid_cyc;
    b_fe    = fe_cnt;
    b_ov    = ov_cnt;
    b_pe    = pe_cnt;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // driver tasks: inputs change 1 time unit after the rising edge
  task automatic cycles(input int n);
    repeat (n) @(posedge clk_hw);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    rx_pin = b;
    cycles(BIT_CYC);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop_bit);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(par);
`else
    if (par === 1'bx) $display("parity bit unused");
`endif
    drive_bit(stop_bit);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop_bit;
    logic [7:0] exp_out;
    int         exp_valid;
    int         exp_fe;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{data: 8'hA5, stop_bit: 1'b1, exp_out: 8'hA5, exp_valid: 1, exp_fe: 0};
    vecs[1] = '{data: 8'h00, stop_bit: 1'b1, exp_out: 8'h00, exp_valid: 1, exp_fe: 0};
    vecs[2] = '{data: 8'hFF, stop_bit: 1'b1, exp_out: 8'hFF, exp_valid: 1, exp_fe: 0};
    vecs[3] = '{data: 8'h3C, stop_bit: 1'b0, exp_out: 8'hFF, exp_valid: 0, exp_fe: 1};
    vecs[4] = '{data: 8'h5A, stop_bit: 1'b1, exp_out: 8'h5A, exp_valid: 1, exp_fe: 0};
    vecs[5] = '{data: 8'h81, stop_bit: 1'b1, exp_out: 8'h81, exp_valid: 1, exp_fe: 0};

    // Reset with the line low
    rst_n = 1'b0;
    rx_pin = 1'b0;
    cycles(3);
    check("rst_data_out", int'(data_out), 8'h00);
    check("rst_data_valid", int'(data_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_flags", int'({frame_err, overrun, parity_err}), 0);
    rx_pin = 1'b1;
    rst_n = 1'b1;
    cycles(5);
    check("idle_busy", int'(busy), 0);

    // Frame table, consumer always ready
    data_ready = 1'b1;
    for (int v = 0; v < 6; v++) begin
      snap();
      send_frame(vecs[v].data, ^vecs[v].data, vecs[v].stop_bit);
      if (!vecs[v].stop_bit) begin
        cycles(40);
        check($sformatf("v%0d_busy_while_low", v), int'(busy), 1);
        rx_pin = 1'b1;
        cycles(20);
      end else begin
        cycles(4);
      end
      check($sformatf("v%0d_data_out", v), int'(data_out), int'(vecs[v].exp_out));
      check($sformatf("v%0d_valid_cycles", v), valid_cyc - b_valid, vecs[v].exp_valid);
      check($sformatf("v%0d_frame_err", v), fe_cnt - b_fe, vecs[v].exp_fe);
      check($sformatf("v%0d_overrun", v), ov_cnt - b_ov, 0);
      check($sformatf("v%0d_parity_err", v), pe_cnt - b_pe, 0);
      check($sformatf("v%0d_busy_after", v), int'(busy), 0);
    end

    // Short low glitch is rejected at mid-start
    snap();
    rx_pin = 1'b0;
    cycles(4);
    rx_pin = 1'b1;
    cycles(12);
    check("glitch_busy", int'(busy), 0);
    check("glitch_valid", valid_cyc - b_valid, 0);
    check("glitch_flags", (fe_cnt - b_fe) + (ov_cnt - b_ov) + (pe_cnt - b_pe), 0);

    // Back-to-back frames into a stalled consumer
    snap();
    data_ready = 1'b0;
    send_frame(8'h11, ^8'h11, 1'b1);
    send_frame(8'h22, ^8'h22, 1'b1);
    cycles(4);
    check("ovr_data_out", int'(data_out), 8'h11);
    check("ovr_data_valid", int'(data_valid), 1);
    check("ovr_pulses", ov_cnt - b_ov, 1);
    data_ready = 1'b1;
    cycles(1);
    check("drain_valid", int'(data_valid), 0);
    check("drain_data_held", int'(data_out), 8'h11);

    // Reset in the middle of a frame with the holding register full
    data_ready = 1'b0;
    send_frame(8'h42, ^8'h42, 1'b1);
    cycles(4);
    check("pre_rst_valid", int'(data_valid), 1);
    snap();
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    rst_n = 1'b0;
    cycles(1);
    check("midrst_busy", int'(busy), 0);
    check("midrst_valid", int'(data_valid), 0);
    check("midrst_data_out", int'(data_out), 8'h00);
    rx_pin = 1'b1;
    rst_n = 1'b1;
    data_ready = 1'b1;
    cycles(4);
    check("midrst_flags", (fe_cnt - b_fe) + (ov_cnt - b_ov) + (pe_cnt - b_pe), 0);
    snap();
    send_frame(8'h99, ^8'h99, 1'b1);
    cycles(4);
    check("recover_data_out", int'(data_out), 8'h99);
    check("recover_valid_cycles", valid_cyc - b_valid, 1);

`ifdef UART_RX_PARITY_EN
    snap();
    send_frame(8'h07, 1'b0, 1'b1);
    cycles(4);
    check("par_bad_pulse", pe_cnt - b_pe, 1);
    check("par_bad_valid", valid_cyc - b_valid, 0);
    check("par_bad_data_held", int'(data_out), 8'h99);
    snap();
    send_frame(8'h07, 1'b1, 1'b1);
    cycles(4);
    check("par_ok_data_out", int'(data_out), 8'h07);
    check("par_ok_valid", valid_cyc - b_valid, 1);
    check("par_ok_pulse", pe_cnt - b_pe, 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
